// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 receiver with filtered clock, framing checks and timeout.
// Maps four configured scancodes onto level "key held" outputs.
module ps2_key_decoder #(
  parameter int         FILT_LEN    = 8,
  parameter int         TIMEOUT_CYC = 200000,
  parameter logic [7:0] CODE0       = 8'h1C,
  parameter logic [7:0] CODE1       = 8'h23,
  parameter logic [7:0] CODE2       = 8'h69,
  parameter logic [7:0] CODE3       = 8'h7A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key_held,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    C_NONE    = 2'b00,
    C_BRK     = 2'b01,
    C_EXT     = 2'b10,
    C_EXT_BRK = 2'b11
  } code_st_e;

  logic [1:0]    ck_sync_q;
  logic [1:0]    dt_sync_q;
  logic          ck_s;
  logic          dt_s;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic          fall;
  logic [3:0]    bit_q;
  logic [10:0]   sh_q;
  logic [10:0]   sh_d;
  logic          frame_ok;
  logic [TW-1:0] idle_q;
  logic [7:0]    rx_byte_q;
  logic          rx_valid_q;
  logic          rx_err_q;
  code_st_e      st_q;
  logic [3:0]    key_q;
  logic [3:0]    hit;
  logic          brk;

  assign ck_s = ck_sync_q[1];
  assign dt_s = dt_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_sync_q <= 2'b11;
      dt_sync_q <= 2'b11;
    end else begin
      ck_sync_q <= {ck_sync_q[0], ps2_clk};
      dt_sync_q <= {dt_sync_q[0], ps2_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (ck_s != filt_q) begin
      if (fcnt_q == FILT_LAST) begin
        filt_q <= ck_s;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end else begin
      fcnt_q <= '0;
    end
  end

  // Strobe on the cycle the filtered clock is about to drop.
  assign fall = filt_q & ~ck_s & (fcnt_q == FILT_LAST);

  assign sh_d     = {dt_s, sh_q[10:1]};
  assign frame_ok = ~sh_d[0] & sh_d[10] & (^sh_d[9:1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q      <= '0;
      sh_q       <= '0;
      idle_q     <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (fall) begin
        idle_q <= '0;
        if (bit_q == 4'd0) begin
          if (!dt_s) begin
            bit_q <= 4'd1;
            sh_q  <= sh_d;
          end
        end else begin
          sh_q <= sh_d;
          if (bit_q == 4'd10) begin
            bit_q <= '0;
            if (frame_ok) begin
              rx_byte_q  <= sh_d[8:1];
              rx_valid_q <= 1'b1;
            end else begin
              rx_err_q <= 1'b1;
            end
          end else begin
            bit_q <= bit_q + 4'd1;
          end
        end
      end else if (bit_q != 4'd0) begin
        if (idle_q == TO_LAST) begin
          rx_err_q <= 1'b1;
          bit_q    <= '0;
          idle_q   <= '0;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end else begin
        idle_q <= '0;
      end
    end
  end

  assign hit = {rx_byte_q == CODE3, rx_byte_q == CODE2,
                rx_byte_q == CODE1, rx_byte_q == CODE0};
  assign brk = (st_q == C_BRK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= C_NONE;
      key_q <= '0;
    end else if (rx_err_q) begin
      st_q <= C_NONE;
    end else if (rx_valid_q) begin
      unique case (1'b1)
        (rx_byte_q == 8'hE0): begin
          st_q <= (st_q == C_BRK || st_q == C_EXT_BRK) ? C_EXT_BRK : C_EXT;
        end
        (rx_byte_q == 8'hF0): begin
          st_q <= (st_q == C_EXT || st_q == C_EXT_BRK) ? C_EXT_BRK : C_BRK;
        end
        default: begin
          st_q <= C_NONE;
          // Extended prefixes never map onto a game key.
          if (st_q == C_NONE || st_q == C_BRK) begin
            key_q <= brk ? (key_q & ~hit) : (key_q | hit);
          end
        end
      endcase
    end
  end

  assign key_held = key_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: framing, codes, errors, reset.
// Runs with FILT_LEN=4, TIMEOUT_CYC=1000 and 50-cycle PS/2 half period.
module tb_ps2_key_decoder;

  localparam int HP = 50;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key_held;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  int n_vec;
  int n_bad;
  int valid_cnt;
  int err_cnt;
  logic [7:0] last_byte;
  logic [3:0] kh_at_valid;
  logic [3:0] kh_after;
  bit pend;

  ps2_key_decoder #(
    .FILT_LEN(4),
    .TIMEOUT_CYC(1000),
    .CODE0(8'h1C),
    .CODE1(8'h23),
    .CODE2(8'h69),
    .CODE3(8'h7A)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .key_held(key_held),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .rx_err(rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pend) kh_after = key_held;
    pend = rx_valid;
    if (rx_valid) begin
      valid_cnt++;
      last_byte = rx_byte;
      kh_at_valid = key_held;
    end
    if (rx_err) err_cnt++;
  end

  task automatic send_frame(input logic [7:0] b, input bit badp,
                            input int nbits, input int glitch);
    logic [10:0] bits;
    logic par;
    par = ~(^b) ^ badp;
    bits = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch) begin
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HP - 22) @(negedge clk);
      end else begin
        repeat (HP) @(negedge clk);
      end
      ps2_clk = 1'b0;
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11, -1);
  endtask

  task automatic chk_keys(input string nm, input logic [3:0] exp);
    n_vec++;
    if (key_held !== exp) begin
      n_bad++;
      $display("FAIL %s: key_held=%b expected %b", nm, key_held, exp);
    end
  endtask

  task automatic test_reset;
    n_vec++;
    if ({key_held, rx_byte, rx_valid, rx_err} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset: keys=%b byte=%h v=%b e=%b expected all 0",
               key_held, rx_byte, rx_valid, rx_err);
    end
  endtask

  task automatic test_basic;
    int v0;
    v0 = valid_cnt;
    send(8'h69);
    n_vec++;
    if (valid_cnt - v0 !== 1 || last_byte !== 8'h69) begin
      n_bad++;
      $display("FAIL basic_rx: pulses=%0d byte=%h expected 1 and 69",
               valid_cnt - v0, last_byte);
    end
    n_vec++;
    if (kh_at_valid !== 4'b0000 || kh_after !== 4'b0100) begin
      n_bad++;
      $display("FAIL basic_lat: at_valid=%b after=%b expected 0000 0100",
               kh_at_valid, kh_after);
    end
    send(8'hF0);
    send(8'h69);
    chk_keys("basic_break", 4'b0000);
  endtask

  task automatic test_overlap;
    send(8'h1C);
    chk_keys("overlap_1c", 4'b0001);
    send(8'h7A);
    chk_keys("overlap_7a", 4'b1001);
    send(8'hF0);
    send(8'h1C);
    chk_keys("overlap_rel", 4'b1000);
  endtask

  task automatic test_extended;
    send(8'h69);
    chk_keys("ext_set", 4'b1100);
    send(8'hE0);
    send(8'h69);
    chk_keys("ext_make", 4'b1100);
    send(8'hE0);
    send(8'hF0);
    send(8'h69);
    chk_keys("ext_break", 4'b1100);
    send(8'hF0);
    send(8'h69);
    chk_keys("ext_after", 4'b1000);
  endtask

  task automatic test_parity;
    int v0;
    int e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'hF0, 1'b1, 11, -1);
    n_vec++;
    if (err_cnt - e0 !== 1 || valid_cnt !== v0) begin
      n_bad++;
      $display("FAIL parity_err: errs=%0d valids=%0d expected 1 0",
               err_cnt - e0, valid_cnt - v0);
    end
    send(8'h69);
    chk_keys("parity_make", 4'b1100);
  endtask

  task automatic test_timeout;
    logic [10:0] bits;
    int e0;
    int n;
    send(8'hF0);
    send(8'h7A);
    chk_keys("to_clear", 4'b0100);
    bits = {1'b1, 1'b1, 8'h55, 1'b0};
    send_frame(8'h55, 1'b0, 4, -1);
    e0 = err_cnt;
    ps2_data = bits[4];
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b0;
    n = 0;
    while (n < 1200 && !rx_err) begin
      @(negedge clk);
      n++;
      if (n == HP) ps2_clk = 1'b1;
    end
    n_vec++;
    if (n < 1004 || n > 1008) begin
      n_bad++;
      $display("FAIL timeout_cyc: cycles=%0d expected 1004..1008", n);
    end
    repeat (HP) @(negedge clk);
    n_vec++;
    if (err_cnt - e0 !== 1) begin
      n_bad++;
      $display("FAIL timeout_err: errs=%0d expected 1", err_cnt - e0);
    end
    ps2_data = 1'b1;
    send_frame(8'h7A, 1'b0, 11, 3);
    n_vec++;
    if (last_byte !== 8'h7A || err_cnt - e0 !== 1) begin
      n_bad++;
      $display("FAIL glitch: byte=%h errs=%0d expected 7a 1",
               last_byte, err_cnt - e0);
    end
    chk_keys("to_make", 4'b1100);
  endtask

  task automatic test_reset_mid;
    int e0;
    send(8'h1C);
    send(8'h23);
    chk_keys("rm_all", 4'b1111);
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 6, -1);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({key_held, rx_byte, rx_valid, rx_err} !== 14'd0) begin
      n_bad++;
      $display("FAIL rst_mid: keys=%b byte=%h v=%b e=%b expected all 0",
               key_held, rx_byte, rx_valid, rx_err);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (HP) @(negedge clk);
    send(8'h23);
    chk_keys("rm_after", 4'b0010);
    n_vec++;
    if (err_cnt !== e0 || last_byte !== 8'h23) begin
      n_bad++;
      $display("FAIL rst_noerr: errs=%0d byte=%h expected 0 23",
               err_cnt - e0, last_byte);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    valid_cnt = 0;
    err_cnt = 0;
    last_byte = '0;
    kh_at_valid = '0;
    kh_after = '0;
    pend = 1'b0;
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    test_basic();
    test_overlap();
    test_extended();
    test_parity();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the PS/2 keyboard serial stream and turns set-2 scancodes into level "key held" signals for the game. Its `key_held[2]` and `key_held[3]` drive the P2 mover's `key_1`/`key_3` inputs; `key_held[0]`/`[1]` drive the P1 mover. The block handles make and break (`F0`) codes and the extended (`E0`) prefix. It also drops malformed or stalled frames so a held key is never stuck or phantom.

## Interface
Parameters:
- `FILT_LEN`, 8: consecutive equal synced samples needed to accept a `ps2_clk` level change.
- `TIMEOUT_CYC`, 200000: idle `clk` cycles mid-frame before the receiver aborts (2 ms at 100 MHz).
- `CODE0`, 8'h1C: scancode for `key_held[0]` ('A', P1 left).
- `CODE1`, 8'h23: scancode for `key_held[1]` ('D', P1 right).
- `CODE2`, 8'h69: scancode for `key_held[2]` (keypad 1, P2 left).
- `CODE3`, 8'h7A: scancode for `key_held[3]` (keypad 3, P2 right).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous, open-drain.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `key_held` out 4: bit i is 1 while the key matching `CODEi` is down.
- `rx_byte` out 8: last byte received with good framing.
- `rx_valid` out 1: one-cycle pulse when `rx_byte` updates.
- `rx_err` out 1: one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- **Input sync and filter**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - The filtered clock changes only after `FILT_LEN` consecutive synced samples differ from its current value. It resets to 1.
  - `fall` is a one-cycle strobe on a 1→0 transition of the filtered clock.
  - Synced data is sampled on `fall`.
- **Frame receiver** (bit counter 0..10, 11-bit shift):
  - Bit 0 is the start bit and must be 0. If it is 1, the frame is discarded silently and the receiver stays idle (no `rx_err`).
  - Bits 1–8 are data, LSB first.
  - Bit 9 is odd parity: the count of ones over data plus parity must be odd.
  - Bit 10 is the stop bit and must be 1.
  - On bit 10, the frame is checked. If it is good, `rx_byte` loads and `rx_valid` pulses. If it is bad, `rx_err` pulses and the byte is dropped.
  - The counter returns to 0 in either case.
- **Timeout**: an idle counter clears on every `fall` and counts while the bit counter is non-zero. When it reaches `TIMEOUT_CYC`, `rx_err` pulses, the counter goes to 0 and the partial frame is discarded.
- **Code FSM** (consumes good bytes only). Flags E (extended) and B (break) both start at 0.
  - `E0`: set E.
  - `F0`: set B.
  - Any other byte is a code. If E=0 and the code equals `CODEi`, set `key_held[i]` = !B. Then clear E and B.
  - Extended codes (E=1) never match. For example, `E0 F0 69` (End release) leaves bit 2 unchanged.
  - Codes matching no `CODEi` only clear E and B.
  - `rx_err` clears E and B and does not change `key_held`.
- **Simultaneous keys**: each bit is independent, so any combination may be held. Choosing between left and right is the mover's job.
- **Repeats**: typematic repeat makes are idempotent.

## Timing
- Reset values:
  - `key_held` = 0, `rx_byte` = 0, `rx_valid` = 0, `rx_err` = 0.
  - Bit counter = 0, E = B = 0.
  - Filtered clock = 1, synchronizers = 1.
- From a raw `ps2_clk` falling edge to `fall`: 2 cycles (sync) + `FILT_LEN` cycles.
- `rx_valid`/`rx_err` are registered and assert the cycle after the bit-10 `fall`.
- `key_held` updates the cycle after `rx_valid`.
- `rst` mid-frame aborts immediately with no `rx_err`. The next frame must begin with a fresh start bit.
- Glitches shorter than `FILT_LEN` cycles on `ps2_clk` produce no `fall`.
- Timeout fires exactly `TIMEOUT_CYC` cycles after the last `fall` of an incomplete frame.

## Test plan
Bench settings for all scenarios: `FILT_LEN`=4, `TIMEOUT_CYC`=1000, PS/2 half-period 50 cycles.

- **Basic make/break**: send `69`, then `F0 69`. Required: `rx_valid` ×1 with `rx_byte`=`69`; `key_held`=4'b0100 one cycle later; after `F0 69`, `key_held`=0.
- **Overlap**: send `1C`, `7A`, `F0 1C`. Required: `key_held` goes 0001 → 1001 → 1000.
- **Extended ignore**: `key_held[2]`=1, then send `E0 69` and `E0 F0 69`. Required: `key_held[2]` stays 1 and E/B end at 0. A following `F0 69` clears the bit.
- **Parity error**: send `F0` with bad parity, then `69`. Required: `rx_err` pulse, no `rx_valid` for `F0`; `69` is treated as a make, so `key_held[2]`=1.
- **Timeout and glitch**: stop after 5 bits, idle 1200 cycles. Required: `rx_err` at 1000 cycles; next full `7A` sets `key_held[3]`. A 2-cycle low glitch on `ps2_clk` causes no bit shift.
- **Reset mid-frame**: assert `rst` at bit 6 with `key_held`=1111. Required: all outputs 0 immediately; a subsequent `23` sets `key_held`=0010.
